// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
//
// Contents:
//   btn_state_e          debouncer FSM state encoding
//   DEF_DEBOUNCE_CYCLES  default number of stable samples to accept a change
//   DEF_REPEAT_CYCLES    default auto-repeat period (only used with BTN_REPEAT_EN)
//   max_int()            helper for sizing the shared counter
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_CYCLES   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
//
// Ports:
//   clk    in   destination clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears both flops
//   d      in   asynchronous input
//   q      out  synchronised copy of d, two clk edges later
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= d;
            sync_q <= s1_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button synchroniser + debouncer with a single-cycle press strobe.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   btn_in       in   raw button, asynchronous, may bounce
//   btn_level    out  debounced button state (registered)
//   press_pulse  out  one-cycle strobe per accepted press (registered)
//
// Build option:
//   BTN_REPEAT_EN  when defined, press_pulse also fires every REPEAT_CYCLES
//                  cycles while the button stays held.
//
// state         | meaning
// --------------+--------------------------------------------------------
// IDLE          | button released and stable
// CHECK_PRESS   | sync high, counting stable high samples
// PRESSED       | press accepted, btn_level high (repeat timer runs here)
// CHECK_RELEASE | sync low while pressed, counting stable low samples
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse
);

    // One counter is shared by debounce and repeat timing, so it is sized
    // for the larger of the two terminal counts.
    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic sync;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (btn_in),
        .q     (sync)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        btn_level_d   = btn_level_q;
        press_pulse_d = 1'b0;   // strobe: high for at most one cycle

        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = CHECK_PRESS;
                    cnt_d   = '0;
                end
            end
            CHECK_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d       = PRESSED;
                    btn_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = CHECK_RELEASE;
                    cnt_d   = '0;
                end
`ifdef BTN_REPEAT_EN
                else if (cnt_q == RPT_LAST) begin
                    press_pulse_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            CHECK_RELEASE: begin
                if (sync) begin
                    // Release bounce: back to held without a new strobe, and
                    // the repeat period restarts from here.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level_q   <= btn_level_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign btn_level   = btn_level_q;
    assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Timing reference: after btn_in changes just after edge j, the first edge
// sampling it is j+1, so a clean press strobes after edge j+7 and a clean
// release drops btn_level after edge j+7.
module tb_btn_debounce_pulse;

    logic clk;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic prev_pulse = 1'b0;
    int p0;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .press_pulse (press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sample point is 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Pulse counter and back-to-back strobe watchdog.
    always @(negedge clk) begin
        if (reset) begin
            if (press_pulse) begin
                pulse_cnt++;
                chk("no_back2back", {31'd0, prev_pulse}, 32'd0);
            end
            prev_pulse = press_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        reset  = 1'b0;
        btn_in = 1'b0;
        repeat (3) step();
        chk("reset_level", {31'd0, btn_level}, 32'd0);
        chk("reset_pulse", {31'd0, press_pulse}, 32'd0);
        reset = 1'b1;
        repeat (3) step();

        // 1. Clean press, held 20 cycles
        p0 = pulse_cnt;
        btn_in = 1'b1;
        repeat (6) step();
        chk("t1_early_pulse", {31'd0, press_pulse}, 32'd0);
        chk("t1_early_level", {31'd0, btn_level}, 32'd0);
        step();
        chk("t1_pulse", {31'd0, press_pulse}, 32'd1);
        chk("t1_level", {31'd0, btn_level}, 32'd1);
        step();
        chk("t1_pulse_off", {31'd0, press_pulse}, 32'd0);
        repeat (12) step();
`ifdef BTN_REPEAT_EN
        chk("t1_count", pulse_cnt - p0, 32'd2);
`else
        chk("t1_count", pulse_cnt - p0, 32'd1);
`endif

        // 6. Release timing after the long hold
        p0 = pulse_cnt;
        btn_in = 1'b0;
        repeat (6) step();
        chk("t6_level_hold", {31'd0, btn_level}, 32'd1);
        step();
        chk("t6_level_fall", {31'd0, btn_level}, 32'd0);
        chk("t6_pulse", {31'd0, press_pulse}, 32'd0);
        repeat (4) step();
        chk("t6_count", pulse_cnt - p0, 32'd0);

        // 2. Bounce on press: never qualifies
        p0 = pulse_cnt;
        btn_in = 1'b1; step(); step();
        btn_in = 1'b0; step();
        btn_in = 1'b1; step();
        btn_in = 1'b0;
        step();
        chk("t2_level_mid", {31'd0, btn_level}, 32'd0);
        repeat (10) step();
        chk("t2_level", {31'd0, btn_level}, 32'd0);
        chk("t2_count", pulse_cnt - p0, 32'd0);

        // 3. Bounce on release: level holds, no second strobe
        p0 = pulse_cnt;
        btn_in = 1'b1;
        repeat (7) step();
        chk("t3_pulse", {31'd0, press_pulse}, 32'd1);
        repeat (3) step();
        btn_in = 1'b0;
        step(); step();
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_level_hold", {31'd0, btn_level}, 32'd1);
        end
        chk("t3_count", pulse_cnt - p0, 32'd1);
        btn_in = 1'b0;
        repeat (10) step();
        chk("t3_released", {31'd0, btn_level}, 32'd0);

        // 4. Reset in the middle of CHECK_PRESS
        p0 = pulse_cnt;
        btn_in = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("t4_rst_level", {31'd0, btn_level}, 32'd0);
        chk("t4_rst_pulse", {31'd0, press_pulse}, 32'd0);
        step();
        reset = 1'b1;
        for (int i = 6; i <= 11; i++) begin
            step();
            chk("t4_requalify_pulse", {31'd0, press_pulse}, 32'd0);
        end
        step();
        chk("t4_pulse", {31'd0, press_pulse}, 32'd1);
        chk("t4_level", {31'd0, btn_level}, 32'd1);
        step();
        chk("t4_count", pulse_cnt - p0, 32'd1);

        // 4b. Reset while pressed clears the level without a clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("t4b_level_async", {31'd0, btn_level}, 32'd0);
        chk("t4b_pulse_async", {31'd0, press_pulse}, 32'd0);
        btn_in = 1'b0;
        step();
        reset = 1'b1;
        repeat (6) step();
        chk("t4b_level_idle", {31'd0, btn_level}, 32'd0);

`ifdef BTN_REPEAT_EN
        // 5. Auto-repeat while held for 40 cycles
        p0 = pulse_cnt;
        btn_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("t5_pulse", {31'd0, press_pulse},
                (i >= 7 && ((i - 7) % 8) == 0) ? 32'd1 : 32'd0);
        end
        btn_in = 1'b0;
        repeat (12) step();
        chk("t5_count", pulse_cnt - p0, 32'd5);
        chk("t5_level", {31'd0, btn_level}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
